// File: rtl/harness_ctrl_if.sv
// Host-to-harness fromhost handshake bundle.
// The host drives valid/data; the harness answers with ready.
interface harness_ctrl_if #(
  parameter int XLEN = 32
);
  logic            host_valid;
  logic [XLEN-1:0] host_data;
  logic            host_ready;

  modport master (
    output host_valid,
    output host_data,
    input  host_ready
  );

  modport slave (
    input  host_valid,
    input  host_data,
    output host_ready
  );
endinterface

// File: rtl/harness_ctrl.sv
// Test harness controller: sequences DUT reset, watches tohost
// channels for a verdict and forwards host words as fromhost strobes.
module harness_ctrl #(
  parameter int CHANNELS     = 1,
  parameter int XLEN         = 32,
  parameter int RESET_CYCLES = 5,
  parameter int TIMEOUT      = 1000000,
  parameter int CNT_W        = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [CHANNELS*XLEN-1:0] tohost,
  input  logic                     host_valid,
  input  logic [XLEN-1:0]          host_data,
  output logic                     host_ready,
  output logic                     dut_reset,
  output logic                     fromhost_valid,
  output logic [XLEN-1:0]          fromhost_bits,
  output logic [CNT_W-1:0]         cycle_count,
  output logic                     done,
  output logic                     pass,
  output logic                     fail,
  output logic                     timed_out,
  output logic [2:0]               fail_channel,
  output logic [XLEN-1:0]          fail_code
);

  typedef enum logic [2:0] {
    S_RST,
    S_RUN,
    S_PASS,
    S_FAIL,
    S_TO
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CHANNELS-1:0] seen_q, seen_d;
  logic                fv_q, fv_d;
  logic [XLEN-1:0]     fb_q, fb_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic                fail_q, fail_d;
  logic                to_q, to_d;
  logic [2:0]          fch_q, fch_d;
  logic [XLEN-1:0]     fcode_q, fcode_d;

  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] bad;
  logic [2:0]          lo_ch;
  logic [XLEN-1:0]     lo_code;
  logic                all_hit;

  always_comb begin
    hit     = '0;
    bad     = '0;
    lo_ch   = '0;
    lo_code = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      hit[i] = tohost[i*XLEN +: XLEN] == XLEN'(1);
      bad[i] = tohost[i*XLEN +: XLEN] >  XLEN'(1);
    end
    // Descending scan so the lowest failing index wins.
    for (int i = CHANNELS-1; i >= 0; i--) begin
      if (bad[i]) begin
        lo_ch   = 3'(i);
        lo_code = tohost[i*XLEN +: XLEN];
      end
    end
    all_hit = &(seen_q | hit);
  end

  always_comb begin
    state_d = state_q;
    seen_d  = seen_q;
    fch_d   = fch_q;
    fcode_d = fcode_q;
    cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    unique case (state_q)
      S_RST: begin
        if (cnt_q == CNT_W'(RESET_CYCLES-1))
          state_d = S_RUN;
      end
      S_RUN: begin
        seen_d = seen_q | hit;
        if (|bad) begin
          state_d = S_FAIL;
          fch_d   = lo_ch;
          fcode_d = lo_code;
        end else if (all_hit) begin
          state_d = S_PASS;
        end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
          state_d = S_TO;
        end
      end
      default: ;
    endcase

    // A word accepted on the edge that leaves RUN is dropped.
    fv_d = 1'b0;
    fb_d = fb_q;
    if (host_valid && host_ready && state_d == S_RUN) begin
      fv_d = 1'b1;
      fb_d = host_data;
    end

    pass_d = state_d == S_PASS;
    fail_d = state_d == S_FAIL;
    to_d   = state_d == S_TO;
    done_d = pass_d | fail_d | to_d;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RST;
      cnt_q   <= '0;
      seen_q  <= '0;
      fv_q    <= 1'b0;
      fb_q    <= '0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
      fch_q   <= '0;
      fcode_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seen_q  <= seen_d;
      fv_q    <= fv_d;
      fb_q    <= fb_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
      fch_q   <= fch_d;
      fcode_q <= fcode_d;
    end
  end

  assign host_ready     = (state_q == S_RUN) && !fv_q;
  assign dut_reset      = state_q == S_RST;
  assign fromhost_valid = fv_q;
  assign fromhost_bits  = fb_q;
  assign cycle_count    = cnt_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign fail           = fail_q;
  assign timed_out      = to_q;
  assign fail_channel   = fch_q;
  assign fail_code      = fcode_q;

endmodule

// File: tb/tb_harness_ctrl.sv
// Randomized and directed bench for harness_ctrl against a
// cycle-level verdict model kept in plain bench variables.
module tb_harness_ctrl;
  localparam int CH = 3;
  localparam int XL = 16;
  localparam int RC = 5;
  localparam int TO = 50;
  localparam int CW = 6;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_RST  = 0;
  localparam int M_RUN  = 1;
  localparam int M_PASS = 2;
  localparam int M_FAIL = 3;
  localparam int M_TO   = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [XL-1:0]   th [CH];
  logic [CH*XL-1:0] tohost;
  logic            dut_reset;
  logic            fromhost_valid;
  logic [XL-1:0]   fromhost_bits;
  logic [CW-1:0]   cycle_count;
  logic            done, pass, fail, timed_out;
  logic [2:0]      fail_channel;
  logic [XL-1:0]   fail_code;

  harness_ctrl_if #(.XLEN(XL)) hif ();

  assign tohost = {th[2], th[1], th[0]};

  harness_ctrl #(
    .CHANNELS(CH), .XLEN(XL), .RESET_CYCLES(RC),
    .TIMEOUT(TO), .CNT_W(CW)
  ) dut (
    .clock(clk),
    .reset(rst_n),
    .tohost(tohost),
    .host_valid(hif.host_valid),
    .host_data(hif.host_data),
    .host_ready(hif.host_ready),
    .dut_reset(dut_reset),
    .fromhost_valid(fromhost_valid),
    .fromhost_bits(fromhost_bits),
    .cycle_count(cycle_count),
    .done(done),
    .pass(pass),
    .fail(fail),
    .timed_out(timed_out),
    .fail_channel(fail_channel),
    .fail_code(fail_code)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  int            m_st;
  int            m_cyc;
  bit            m_seen [CH];
  int            m_fch;
  logic [XL-1:0] m_fcode;
  bit            m_fv;
  logic [XL-1:0] m_fb;
  int            n_hs;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_st    = M_RST;
    m_cyc   = 0;
    for (int i = 0; i < CH; i++) m_seen[i] = 1'b0;
    m_fch   = 0;
    m_fcode = '0;
    m_fv    = 1'b0;
    m_fb    = '0;
    n_hs    = 0;
  endtask

  task automatic check_all();
    chk("dut_reset", dut_reset, m_st == M_RST);
    chk("host_ready", hif.host_ready, m_st == M_RUN && !m_fv);
    chk("fh_valid", fromhost_valid, m_fv);
    chk("fh_bits", fromhost_bits, m_fb);
    chk("cycle_count", cycle_count, m_cyc);
    chk("done", done, m_st >= M_PASS);
    chk("pass", pass, m_st == M_PASS);
    chk("fail", fail, m_st == M_FAIL);
    chk("timed_out", timed_out, m_st == M_TO);
    chk("fail_channel", fail_channel, m_fch);
    chk("fail_code", fail_code, m_fcode);
  endtask

  // Advance the model across one rising edge with the current inputs.
  task automatic m_step();
    int nst;
    bit anyf;
    bit allp;
    bit hs;
    hs   = hif.host_valid && m_st == M_RUN && !m_fv;
    nst  = m_st;
    anyf = 1'b0;
    allp = 1'b1;
    if (m_st == M_RST) begin
      if (m_cyc == RC - 1) nst = M_RUN;
    end else if (m_st == M_RUN) begin
      for (int i = 0; i < CH; i++)
        if (th[i] > 1 && !anyf) begin
          anyf = 1'b1;
          m_fch = i;
          m_fcode = th[i];
        end
      for (int i = 0; i < CH; i++)
        if (th[i] == 1) m_seen[i] = 1'b1;
      for (int i = 0; i < CH; i++)
        allp &= m_seen[i];
      if (anyf) nst = M_FAIL;
      else if (allp) nst = M_PASS;
      else if (m_cyc >= TO) nst = M_TO;
    end
    m_fv = hs && nst == M_RUN;
    if (m_fv) begin
      m_fb = hif.host_data;
      n_hs++;
    end
    m_cyc = (m_cyc < CMAX) ? m_cyc + 1 : CMAX;
    m_st = nst;
  endtask

  task automatic tick();
    m_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic zero_in();
    for (int i = 0; i < CH; i++) th[i] = '0;
    hif.host_valid = 1'b0;
    hif.host_data  = '0;
  endtask

  // Called at a negedge: async assert, check, release next negedge.
  task automatic do_reset();
    rst_n = 1'b0;
    zero_in();
    #1;
    m_reset();
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
    check_all();
  endtask

  function automatic logic [XL-1:0] rnd_th();
    int r;
    r = $urandom_range(0, 999);
    if (r < 960) return '0;
    if (r < 995) return XL'(1);
    return XL'($urandom_range(2, 65535));
  endfunction

  int ev;
  int sv [$];
  logic [XL-1:0] sb [$];

  initial begin
    zero_in();
    @(negedge clk);
    do_reset();

    // All channels report 1 at cycle 20; saturate the counter after.
    ev = -1;
    for (int k = 0; k < 70; k++) begin
      for (int i = 0; i < CH; i++) th[i] = XL'(m_cyc == 20);
      tick();
      if (pass && ev < 0) ev = cycle_count;
    end
    chk("pass_at_21", ev, 21);
    chk("cnt_sat", cycle_count, CMAX);

    // Staggered channel passes complete at cycle 15.
    do_reset();
    ev = -1;
    for (int k = 0; k < 25; k++) begin
      th[0] = XL'(m_cyc == 10);
      th[2] = XL'(m_cyc == 12);
      th[1] = XL'(m_cyc == 15);
      tick();
      if (pass && ev < 0) ev = cycle_count;
    end
    chk("stagger_pass", ev, 16);

    // Two channels fail together; lowest index is latched.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      th[0] = (m_cyc == 10) ? XL'(7) : '0;
      th[2] = (m_cyc == 10) ? XL'(9) : '0;
      tick();
    end
    chk("dual_fail_ch", fail_channel, 0);
    chk("dual_fail_code", fail_code, 7);

    // Fail beats completing pass in the same cycle.
    do_reset();
    for (int k = 0; k < 20; k++) begin
      th[2] = XL'(m_cyc == 9);
      th[1] = (m_cyc == 8) ? XL'(1) : (m_cyc == 12) ? XL'(3) : '0;
      th[0] = XL'(m_cyc == 12);
      tick();
    end
    chk("prio_fail", fail, 1);
    chk("prio_fail_ch", fail_channel, 1);
    chk("prio_fail_code", fail_code, 3);

    // Timeout with idle tohost.
    do_reset();
    ev = -1;
    for (int k = 0; k < 60; k++) begin
      tick();
      if (timed_out && ev < 0) ev = cycle_count;
    end
    chk("timeout_at_51", ev, 51);

    // A verdict in the timeout cycle wins.
    do_reset();
    for (int k = 0; k < 60; k++) begin
      for (int i = 0; i < CH; i++) th[i] = XL'(m_cyc == TO);
      tick();
    end
    chk("edge_pass", pass, 1);
    chk("edge_no_to", timed_out, 0);

    // Held host_valid: A5 then 5A, one strobe each, 2 cycles apart.
    do_reset();
    sv.delete();
    sb.delete();
    for (int k = 0; k < 12; k++) begin
      hif.host_valid = 1'b1;
      hif.host_data  = (n_hs == 0) ? XL'(16'hA5) : XL'(16'h5A);
      tick();
      if (fromhost_valid) begin
        sv.push_back(int'(cycle_count));
        sb.push_back(fromhost_bits);
      end
    end
    chk("strobe_cnt_ge2", sv.size() >= 2, 1);
    if (sv.size() >= 2) begin
      chk("strobe0_bits", sb[0], 16'hA5);
      chk("strobe1_bits", sb[1], 16'h5A);
      chk("strobe_gap", sv[1] - sv[0], 2);
      chk("strobe0_cyc", sv[0], RC + 1);
    end

    // Reset pulsed mid-RUN at cycle 30, then a fresh sequence.
    do_reset();
    for (int k = 0; k < 30; k++) begin
      hif.host_valid = 1'($urandom_range(0, 1));
      hif.host_data  = XL'($urandom);
      tick();
    end
    do_reset();
    for (int k = 0; k < 10; k++) tick();

    // Random runs with occasional mid-run resets.
    for (int r = 0; r < 40; r++) begin
      do_reset();
      for (int k = 0; k < 70; k++) begin
        if ($urandom_range(0, 199) == 0) begin
          do_reset();
        end else begin
          for (int i = 0; i < CH; i++) th[i] = rnd_th();
          hif.host_valid = 1'($urandom_range(0, 1));
          hif.host_data  = XL'($urandom);
          tick();
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
